mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the instruction-fetch and data-memory requests of the pipelined CPU onto the single shared RAM port.
- Generates the ihit/dhit strobes that the hazard unit consumes to stall and flush pipeline latches.
- Data requests have priority over instruction requests. A streak limit bounds how long fetch can starve.
- Detects RAM error and timeout, and reports both through a sticky error flag.

Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while iREN is pending before one instruction grant is forced.
- TIMEOUT_CYC, 255: cycles allowed in an access state without ramstate==ACCESS before error.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request; held by the requester until ihit
- iaddr  in  32  instruction address
- iload  out  32  registered instruction read data
- ihit  out  1  one-cycle instruction completion strobe
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dload  out  32  registered data read data
- dhit  out  1  one-cycle data completion strobe
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address, with bits [1:0] forced to 0
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ramstate==ACCESS
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err  out  1  sticky error flag

Behaviour:
- States: IDLE, IACC, DACC, IHIT, DHIT, ERR. All outputs decode from registered state and latches (Moore).
- Reset: state=IDLE; all outputs 0; iload=dload=0; streak, timeout and address/data latches all 0.
- Reset mid-access drops ramREN/ramWEN in the cycle after the reset edge. No hit is generated for the aborted request.
- IDLE grant rules, evaluated in priority order:
  - (dREN|dWEN) & iREN & streak==MAX_D_STREAK -> IACC, streak=0.
  - (dREN|dWEN) -> DACC, streak = iREN ? streak+1 (saturating) : 0.
  - iREN -> IACC, streak=0.
  - Otherwise stay in IDLE.
- On a grant, latch the address, dstore, and op: write if dWEN, else read. dWEN & dREN together counts as a write.
- IACC: ramREN=1, ramaddr=latched iaddr.
- DACC: ramREN = ~op_write, ramWEN = op_write, ramaddr = latched daddr, ramstore = latched dstore.
- Request inputs are not re-sampled while in IACC or DACC.
- In IACC/DACC:
  - ramstate==ACCESS -> capture ramload into iload (IACC) or dload (DACC read only; a write leaves dload unchanged); go to IHIT/DHIT.
  - ramstate==ERROR, or timeout counter reaches TIMEOUT_CYC -> ERR.
  - FREE or BUSY -> stay; timeout counter increments each cycle.
- IHIT/DHIT: ihit or dhit =1 for exactly one cycle; RAM enables are 0; next state is IDLE.
- Timeout counter clears on entry to IACC/DACC.
- Minimum latency: request visible in cycle N, RAM enable in N+1, ACCESS in N+1, hit in N+2. IDLE re-samples requests in N+3.
- ERR: err=1; RAM enables, ihit and dhit held 0; the state is left only by RST.
- ramaddr and ramstore are 0 whenever the corresponding enable is 0.

Optional Feature:
- Macro: MEM_ARBITER_STATS_EN.
- When defined, adds three outputs:
  - icount [31:0]: completed instruction accesses.
  - dcount [31:0]: completed data accesses.
  - stallcount [31:0]: cycles in IACC or DACC.
- All three counters reset to 0 and wrap at 2^32.
- When not defined, these ports and the counter logic do not exist. Core behaviour is identical either way.

Test Plan:
- Single fetch: iREN=1, iaddr=0x00000040; RAM returns ACCESS immediately with ramload=0x8C010004 -> ramREN=1 and ramaddr=0x40 in cycle 1; ihit=1 and iload=0x8C010004 in cycle 2; no dhit.
- Data priority: iREN=1 and dREN=1 in the same cycle, RAM in BUSY for 3 cycles then ACCESS -> DACC first; dhit pulses after 5 cycles; IACC follows; the later ihit is 1 cycle wide.
- Streak limit: dWEN held continuously with new addresses, iREN=1, MAX_D_STREAK=4 -> 4 data grants, then exactly one instruction grant, then data grants resume.
- Write: dWEN=1, daddr=0x00000103, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramaddr=0x100, ramstore=0xDEADBEEF; dhit pulses; dload unchanged.
- Error and timeout: ramstate=ERROR during DACC -> err=1 the next cycle, no dhit. Separately, ramstate held BUSY with TIMEOUT_CYC=8 -> err=1 after 8 cycles. Both cases clear only on RST=1.
- Reset mid-access: RST asserted while in DACC with BUSY -> ramREN, ramWEN and dhit are 0 the next cycle; state IDLE; a fresh iREN is then serviced normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU fetch/data request ports plus the shared RAM port.
// The arbiter takes the slave modport; the CPU/RAM side (or a bench) takes master.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shared-RAM arbiter: data-first with a fetch anti-starvation streak limit, Moore hit strobes,
// sticky error on RAM ERROR or timeout. Define MEM_ARBITER_STATS_EN for access/stall counters.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic        CLK,
  input  logic        RST,
  mem_arbiter_if.slave bus
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stallcount
`endif
);

  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]    RAM_ACCESS = 2'd2;
  localparam logic [1:0]    RAM_ERROR  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_IACC, S_DACC, S_IHIT, S_DHIT, S_ERR} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic [TW-1:0]  tmo_q;
  logic           grant_i, grant_d;
  logic [31:0]    addr_q, store_q, iload_q, dload_q;
  logic           opw_q;
  logic           dreq, in_acc, ram_ok;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == STREAK_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  assign dreq   = bus.dREN | bus.dWEN;
  assign in_acc = (state_q == S_IACC) || (state_q == S_DACC);
  assign ram_ok = (bus.ramstate == RAM_ACCESS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      streak_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (grant_i || grant_d) tmo_q <= '0;
      else if (in_acc)        tmo_q <= tmo_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dreq && bus.iREN && streak_q == STREAK_MAX) begin
          state_d  = S_IACC;
          streak_d = '0;
          grant_i  = 1'b1;
        end else if (dreq) begin
          state_d  = S_DACC;
          streak_d = bus.iREN ? sat_inc(streak_q) : '0;
          grant_d  = 1'b1;
        end else if (bus.iREN) begin
          state_d  = S_IACC;
          streak_d = '0;
          grant_i  = 1'b1;
        end
      end
      S_IACC, S_DACC: begin
        if (ram_ok)
          state_d = (state_q == S_IACC) ? S_IHIT : S_DHIT;
        else if (bus.ramstate == RAM_ERROR || tmo_q == TMO_LAST)
          state_d = S_ERR;
      end
      S_IHIT, S_DHIT: state_d = S_IDLE;
      S_ERR:          state_d = S_ERR;
      default:        state_d = S_IDLE;
    endcase
  end

  // Request latches and read-data capture; requests are not re-sampled during an access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '0;
      store_q <= '0;
      opw_q   <= 1'b0;
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      if (grant_i || grant_d) begin
        addr_q  <= grant_d ? bus.daddr : bus.iaddr;
        store_q <= bus.dstore;
        opw_q   <= grant_d & bus.dWEN;
      end
      if (state_q == S_IACC && ram_ok)           iload_q <= bus.ramload;
      if (state_q == S_DACC && ram_ok && !opw_q) dload_q <= bus.ramload;
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ihit     = 1'b0;
    bus.dhit     = 1'b0;
    bus.err      = 1'b0;
    bus.iload    = iload_q;
    bus.dload    = dload_q;
    case (state_q)
      S_IACC: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = word_align(addr_q);
      end
      S_DACC: begin
        bus.ramREN   = ~opw_q;
        bus.ramWEN   = opw_q;
        bus.ramaddr  = word_align(addr_q);
        bus.ramstore = opw_q ? store_q : '0;
      end
      S_IHIT:  bus.ihit = 1'b1;
      S_DHIT:  bus.dhit = 1'b1;
      S_ERR:   bus.err  = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_ARBITER_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount     <= '0;
      dcount     <= '0;
      stallcount <= '0;
    end else begin
      if (state_q == S_IHIT) icount     <= icount + 32'd1;
      if (state_q == S_DHIT) dcount     <= dcount + 32'd1;
      if (in_acc)            stallcount <= stallcount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural RAM with programmable BUSY latency plus a hit scoreboard
// that holds the expected iload/dload for every request issued.
module tb_mem_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 8;
  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  mem_arbiter_if bus();
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] icount, dcount, stallcount;
`endif

  mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .icount(icount),
    .dcount(dcount),
    .stallcount(stallcount)
`endif
  );

  always #5 CLK = ~CLK;

  int   busy_lat = 0;
  int   busy_cnt = 0;
  logic force_err = 1'b0;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    return (a * 32'd3) ^ 32'h1234_5678;
  endfunction

  always @(posedge CLK) busy_cnt <= (bus.ramREN | bus.ramWEN) ? busy_cnt + 1 : 0;

  assign bus.ramstate = force_err ? R_ERROR :
                        !(bus.ramREN | bus.ramWEN) ? R_FREE :
                        (busy_cnt < busy_lat) ? R_BUSY : R_ACCESS;
  assign bus.ramload  = (bus.ramstate == R_ACCESS) ? ram_word(bus.ramaddr) : 32'h0BAD_0BAD;

  logic [31:0] iq[$];
  logic [31:0] dq[$];
  logic [31:0] model_dload = 32'h0;
  logic [31:0] e_i, e_d;
  int n_cmp = 0;
  int n_fail = 0;

  always @(negedge CLK) begin
    if (!RST && bus.ihit) begin
      n_cmp++;
      if (iq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_ihit: unexpected ihit, iload=%h", bus.iload);
      end else begin
        e_i = iq.pop_front();
        if (bus.iload !== e_i) begin
          n_fail++;
          $display("FAIL sb_iload: got %h expected %h", bus.iload, e_i);
        end
      end
    end
    if (!RST && bus.dhit) begin
      n_cmp++;
      if (dq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_dhit: unexpected dhit, dload=%h", bus.dload);
      end else begin
        e_d = dq.pop_front();
        if (bus.dload !== e_d) begin
          n_fail++;
          $display("FAIL sb_dload: got %h expected %h", bus.dload, e_d);
        end
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ren/wen/ihit/dhit/err=%b expected 00000",
               {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err});
    end
    n_cmp++;
    if (bus.iload !== 32'h0 || bus.dload !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_load: iload=%h dload=%h expected 0", bus.iload, bus.dload);
    end
    n_cmp++;
    if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_bus: ramaddr=%h ramstore=%h expected 0", bus.ramaddr, bus.ramstore);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    busy_lat = 0;
    bus.iREN = 1'b1;
    bus.iaddr = 32'h40;
    iq.push_back(32'h8C01_0004);
    tick();
    n_cmp++;
    if (bus.ramREN !== 1'b1 || bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h40) begin
      n_fail++;
      $display("FAIL fetch_c1: ren=%b wen=%b addr=%h expected 1 0 00000040",
               bus.ramREN, bus.ramWEN, bus.ramaddr);
    end
    tick();
    n_cmp++;
    if (bus.ihit !== 1'b1 || bus.dhit !== 1'b0 || bus.iload !== 32'h8C01_0004) begin
      n_fail++;
      $display("FAIL fetch_c2: ihit=%b dhit=%b iload=%h expected 1 0 8c010004",
               bus.ihit, bus.dhit, bus.iload);
    end
    bus.iREN = 1'b0;
    tick();
    n_cmp++;
    if (bus.ihit !== 1'b0 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL fetch_c3: ihit=%b ren=%b addr=%h expected 0 0 0", bus.ihit, bus.ramREN, bus.ramaddr);
    end
  endtask

  task automatic test_data_priority();
    int cyc;
    busy_lat = 3;
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    bus.dREN = 1'b1; bus.daddr = 32'h200;
    model_dload = ram_word(32'h200);
    dq.push_back(model_dload);
    iq.push_back(ram_word(32'h80));
    tick();
    cyc = 1;
    n_cmp++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h200) begin
      n_fail++;
      $display("FAIL prio_first: ren=%b addr=%h expected 1 00000200", bus.ramREN, bus.ramaddr);
    end
    while (bus.dhit !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    n_cmp++;
    if (cyc != 5) begin
      n_fail++;
      $display("FAIL prio_dhit_cycle: dhit at cycle %0d expected 5", cyc);
    end
    bus.dREN = 1'b0;
    while (bus.ihit !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    n_cmp++;
    if (cyc != 11) begin
      n_fail++;
      $display("FAIL prio_ihit_cycle: ihit at cycle %0d expected 11", cyc);
    end
    bus.iREN = 1'b0;
    tick();
    n_cmp++;
    if (bus.ihit !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_ihit_width: ihit=%b one cycle after pulse, expected 0", bus.ihit);
    end
    busy_lat = 0;
  endtask

  task automatic test_streak();
    logic [5:0] grant_seq;
    int ng, d_done, cyc;
    logic i_done;
    grant_seq = '0; ng = 0; d_done = 0; i_done = 1'b0; cyc = 0;
    busy_lat = 0;
    bus.dWEN = 1'b1; bus.daddr = 32'h1000; bus.dstore = 32'h1111_0000;
    dq.push_back(model_dload);
    bus.iREN = 1'b1; bus.iaddr = 32'h88;
    iq.push_back(ram_word(32'h88));
    while (!(d_done == 5 && i_done) && cyc < 80) begin
      tick();
      cyc++;
      if ((bus.ramREN | bus.ramWEN) && ng < 6) begin
        grant_seq = {grant_seq[4:0], bus.ramWEN};
        ng++;
      end
      if (bus.dhit) begin
        d_done++;
        if (d_done < 5) begin
          bus.daddr = bus.daddr + 32'h10;
          bus.dstore = bus.dstore + 32'h1;
          dq.push_back(model_dload);
        end else bus.dWEN = 1'b0;
      end
      if (bus.ihit) begin
        bus.iREN = 1'b0;
        i_done = 1'b1;
      end
    end
    n_cmp++;
    if (d_done != 5 || !i_done) begin
      n_fail++;
      $display("FAIL streak_done: data hits=%0d fetch done=%b expected 5 1", d_done, i_done);
    end
    n_cmp++;
    if (grant_seq !== 6'b111101) begin
      n_fail++;
      $display("FAIL streak_order: grants=%b (1=data) expected 111101", grant_seq);
    end
    bus.dWEN = 1'b0; bus.iREN = 1'b0;
    tick();
  endtask

  task automatic test_write();
    busy_lat = 0;
    bus.dWEN = 1'b1; bus.daddr = 32'h103; bus.dstore = 32'hDEAD_BEEF;
    dq.push_back(model_dload);
    tick();
    n_cmp++;
    if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramaddr !== 32'h100 ||
        bus.ramstore !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_bus: wen=%b ren=%b addr=%h store=%h expected 1 0 00000100 deadbeef",
               bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
    end
    tick();
    n_cmp++;
    if (bus.dhit !== 1'b1 || bus.dload !== model_dload || bus.ramstore !== 32'h0) begin
      n_fail++;
      $display("FAIL write_hit: dhit=%b dload=%h store=%h expected 1 %h 0",
               bus.dhit, bus.dload, bus.ramstore, model_dload);
    end
    bus.dWEN = 1'b0;
    tick();
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h204; bus.dstore = 32'h5555_AAAA;
    dq.push_back(model_dload);
    tick();
    n_cmp++;
    if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL write_both: wen=%b ren=%b expected 1 0", bus.ramWEN, bus.ramREN);
    end
    tick();
    bus.dWEN = 1'b0; bus.dREN = 1'b0;
    tick();
  endtask

  task automatic test_error();
    logic bad;
    int first_err;
    force_err = 1'b1;
    bus.dREN = 1'b1; bus.daddr = 32'h300;
    tick();
    tick();
    n_cmp++;
    if (bus.err !== 1'b1 || bus.dhit !== 1'b0 || bus.ramREN !== 1'b0) begin
      n_fail++;
      $display("FAIL err_ramerror: err=%b dhit=%b ren=%b expected 1 0 0", bus.err, bus.dhit, bus.ramREN);
    end
    force_err = 1'b0;
    bus.dREN = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (bus.err !== 1'b1 || bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b ren=%b ihit=%b expected 1 0 0", bus.err, bus.ramREN, bus.ihit);
    end
    bus.iREN = 1'b0;
    RST = 1'b1;
    tick();
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b after RST expected 0", bus.err);
    end
    RST = 1'b0;
    tick();
    busy_lat = 1000;
    bus.dREN = 1'b1; bus.daddr = 32'h310;
    first_err = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.err === 1'b1 && first_err == 0) first_err = c;
    end
    n_cmp++;
    if (first_err != TMO + 1) begin
      n_fail++;
      $display("FAIL err_timeout: err first seen cycle %0d expected %0d", first_err, TMO + 1);
    end
    bus.dREN = 1'b0;
    RST = 1'b1;
    tick();
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_timeout_clear: err=%b after RST expected 0", bus.err);
    end
    RST = 1'b0;
    busy_lat = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    busy_lat = 1000;
    bus.dREN = 1'b1; bus.daddr = 32'h400;
    tick();
    n_cmp++;
    if (bus.ramREN !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_access: ren=%b expected 1", bus.ramREN);
    end
    tick();
    RST = 1'b1;
    tick();
    n_cmp++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.dhit !== 1'b0 || bus.ramaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_drop: ren=%b wen=%b dhit=%b addr=%h expected 0 0 0 0",
               bus.ramREN, bus.ramWEN, bus.dhit, bus.ramaddr);
    end
    RST = 1'b0;
    bus.dREN = 1'b0;
    busy_lat = 0;
    model_dload = 32'h0;
    tick();
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    iq.push_back(ram_word(32'h44));
    cyc = 0;
    while (bus.ihit !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    n_cmp++;
    if (cyc != 2) begin
      n_fail++;
      $display("FAIL rstmid_refetch: ihit at cycle %0d expected 2", cyc);
    end
    bus.iREN = 1'b0;
    tick();
  endtask

  initial begin
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    test_reset();
    test_single_fetch();
    test_data_priority();
    test_streak();
    test_write();
    test_error();
    test_reset_mid();
    repeat (2) tick();
    n_cmp++;
    if (iq.size() != 0 || dq.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: pending fetch=%0d data=%0d expected 0 0", iq.size(), dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
